// File: rtl/pmod_pos_receiver_pkg.sv
// Shared definitions for the inter-board position link (master receiver and slave transmitter).
package pmod_pos_receiver_pkg;

   localparam int unsigned POS_W  = 12;
   localparam int unsigned LINK_W = 2 * POS_W;

   // Pin map: which position bit each Pmod's bit 0 carries.
   localparam int unsigned JA_Y_LSB    = 4;  // JA[7:0] -> ypos[11:4]
   localparam int unsigned JB_X_LSB    = 0;  // JB[7:0] -> xpos[7:0]
   localparam int unsigned JC_X_LSB    = 8;  // JC[3:0] -> xpos[11:8]
   localparam int unsigned JC_Y_LSB    = 0;  // JC[7:4] -> ypos[3:0]

   // Screen limits for the 1024x768 display.
   localparam logic [POS_W-1:0] X_MAX_DEF = 12'd1023;
   localparam logic [POS_W-1:0] Y_MAX_DEF = 12'd767;

   // Pack the three Pmods into the link word {ypos, xpos}.
   function automatic logic [LINK_W-1:0] pack_link(input logic [7:0] ja, input logic [7:0] jb,
                                                   input logic [7:0] jc);
      return {ja, jc[7:4], jc[3:0], jb};
   endfunction

   // Unsigned upper clamp.
   function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] v,
                                                  input logic [POS_W-1:0] lim);
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/pmod_sync.sv
// Generic-width two-flop synchronizer with asynchronous active-low reset.
module pmod_sync #(
   parameter int unsigned Width = 24
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] meta_q;
   logic [Width-1:0] sync_q;

   // Two back-to-back flops; the first may go metastable, the second settles it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pmod_pos_receiver.sv
// Master-board receiver: synchronizes the static Pmod position word, waits for it to be stable,
// clamps it to the screen and presents it with a one-cycle valid pulse.
module pmod_pos_receiver
   import pmod_pos_receiver_pkg::*;
#(
   parameter int unsigned     STABLE_CYCLES = 4,
   parameter logic [POS_W-1:0] X_MAX        = X_MAX_DEF,
   parameter logic [POS_W-1:0] Y_MAX        = Y_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        JA,
   input  logic [7:0]        JB,
   input  logic [7:0]        JC,
   output logic [POS_W-1:0]  xpos,
   output logic [POS_W-1:0]  ypos,
   output logic              pos_valid,
   output logic [7:0]        glitch_cnt
);

   localparam int unsigned     CntW    = $clog2(STABLE_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax  = CntW'(STABLE_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

   logic [LINK_W-1:0] w_s;

   logic [LINK_W-1:0] cand_q, cand_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [LINK_W-1:0] committed_q, committed_d;
   logic [POS_W-1:0]  xpos_q, xpos_d;
   logic [POS_W-1:0]  ypos_q, ypos_d;
   logic              valid_q, valid_d;
   logic [7:0]        glitch_q, glitch_d;
   logic              commit;

   pmod_sync #(
      .Width (LINK_W)
   ) u_sync (
      .clk_i  (clk),
      .rst_ni (rst),
      .d_i    (pack_link(JA, JB, JC)),
      .q_o    (w_s)
   );

   // Stability filter, commit decision, clamp and glitch accounting.
   always_comb begin
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      committed_d = committed_q;
      xpos_d      = xpos_q;
      ypos_d      = ypos_q;
      glitch_d    = glitch_q;
      commit      = 1'b0;

      if (w_s != cand_q) begin
         cand_d = w_s;
         cnt_d  = '0;
         // A candidate abandoned before it could commit is a glitch, unless it was
         // just the already-committed word reappearing.
         if ((cnt_q < CntMax) && (cand_q != committed_q) && (glitch_q != 8'hFF)) begin
            glitch_d = glitch_q + 8'd1;
         end
      end else if (cnt_q < CntLast) begin
         cnt_d = cnt_q + 1'b1;
      end else if (cnt_q == CntLast) begin
         cnt_d  = CntMax;
         commit = (cand_q != committed_q);
      end

      if (commit) begin
         committed_d = cand_q;
         xpos_d      = clamp_pos(cand_q[POS_W-1:0], X_MAX);
         ypos_d      = clamp_pos(cand_q[LINK_W-1:POS_W], Y_MAX);
      end
      valid_d = commit;
   end

   // Filter and output state; cnt resets saturated so nothing commits straight out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cand_q      <= '0;
         cnt_q       <= CntMax;
         committed_q <= '0;
         xpos_q      <= '0;
         ypos_q      <= '0;
         valid_q     <= 1'b0;
         glitch_q    <= '0;
      end else begin
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         committed_q <= committed_d;
         xpos_q      <= xpos_d;
         ypos_q      <= ypos_d;
         valid_q     <= valid_d;
         glitch_q    <= glitch_d;
      end
   end

   assign xpos       = xpos_q;
   assign ypos       = ypos_q;
   assign pos_valid  = valid_q;
   assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_pmod_pos_receiver.sv
// Scoreboard bench for pmod_pos_receiver: stimulus pushes expected commits, a monitor checks pulses.
module tb_pmod_pos_receiver;

   localparam int unsigned STABLE = 4;
   localparam int unsigned LAT    = STABLE + 3;

   typedef struct packed {
      logic [11:0] x;
      logic [11:0] y;
      int unsigned cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  JA = '0, JB = '0, JC = '0;
   logic [11:0] xpos, ypos;
   logic        pos_valid;
   logic [7:0]  glitch_cnt;

   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        sb_q[$];

   logic [11:0] prev_x = '0, prev_y = '0;
   logic        prev_v = 1'b0;

   pmod_pos_receiver #(
      .STABLE_CYCLES (STABLE),
      .X_MAX         (12'd1023),
      .Y_MAX         (12'd767)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .JA         (JA),
      .JB         (JB),
      .JC         (JC),
      .xpos       (xpos),
      .ypos       (ypos),
      .pos_valid  (pos_valid),
      .glitch_cnt (glitch_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   task automatic drive(input logic [11:0] x, input logic [11:0] y);
      JA = y[11:4];
      JB = x[7:0];
      JC = {y[3:0], x[11:8]};
   endtask

   // Expected commit timed from the cycle the pins were last changed.
   task automatic expect_commit(input logic [11:0] x, input logic [11:0] y);
      exp_t e;
      e.x   = x;
      e.y   = y;
      e.cyc = cyc + LAT;
      sb_q.push_back(e);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every pulse must match the oldest expectation; outputs never move without one.
   always @(negedge clk) begin
      if (!rst) begin
         prev_x = xpos;
         prev_y = ypos;
         prev_v = 1'b0;
      end else begin
         if (pos_valid) begin
            check("pulse_not_back_to_back", {31'd0, prev_v}, 32'd0);
            if (sb_q.size() == 0) begin
               check("unexpected_pos_valid", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("commit_xpos", {20'd0, xpos}, {20'd0, e.x});
               check("commit_ypos", {20'd0, ypos}, {20'd0, e.y});
               check("commit_cycle", cyc, e.cyc);
            end
         end else begin
            check("outputs_stable_without_pulse", {8'd0, xpos, ypos}, {8'd0, prev_x, prev_y});
         end
         prev_x = xpos;
         prev_y = ypos;
         prev_v = pos_valid;
      end
   end

   initial begin
      // Reset state with a word already on the pins.
      drive(12'h123, 12'h045);
      wait_cycles(3);
      check("reset_xpos", {20'd0, xpos}, 32'd0);
      check("reset_ypos", {20'd0, ypos}, 32'd0);
      check("reset_valid", {31'd0, pos_valid}, 32'd0);
      check("reset_glitch", {24'd0, glitch_cnt}, 32'd0);
      rst = 1'b1;
      expect_commit(12'h123, 12'h045);
      wait_cycles(12);
      check("first_glitch", {24'd0, glitch_cnt}, 32'd0);

      // Skewed transition: JB first, JC/JA two cycles later. Only the partial word
      // (x=0x100) is abandoned mid-count; the first change starts from a settled count.
      JB = 8'h00;
      wait_cycles(2);
      JC = 8'h02;
      JA = 8'h10;
      expect_commit(12'h200, 12'h100);
      wait_cycles(12);
      check("skew_glitch", {24'd0, glitch_cnt}, 32'd1);

      // Clamp: above range, then exactly at range (different raw word, still commits).
      drive(12'h7FF, 12'h300);
      expect_commit(12'd1023, 12'd767);
      wait_cycles(12);
      drive(12'h3FF, 12'h2FF);
      expect_commit(12'd1023, 12'd767);
      wait_cycles(12);
      check("clamp_glitch", {24'd0, glitch_cnt}, 32'd1);

      // Bounce: brief excursion returning to the committed word.
      drive(12'h010, 12'h010);
      expect_commit(12'h010, 12'h010);
      wait_cycles(12);
      drive(12'h011, 12'h010);
      wait_cycles(2);
      drive(12'h010, 12'h010);
      wait_cycles(12);
      check("bounce_glitch", {24'd0, glitch_cnt}, 32'd2);
      check("bounce_xpos", {20'd0, xpos}, 32'h010);
      check("bounce_ypos", {20'd0, ypos}, 32'h010);

      // Continuous toggling: never stable, glitch count saturates.
      for (int i = 0; i < 600; i++) begin
         JB[0] = ~JB[0];
         wait_cycles(1);
      end
      wait_cycles(12);
      check("toggle_glitch_sat", {24'd0, glitch_cnt}, 32'd255);
      check("toggle_xpos", {20'd0, xpos}, 32'h010);
      wait_cycles(20);
      check("toggle_glitch_hold", {24'd0, glitch_cnt}, 32'd255);

      // Reset while the candidate count is at 2.
      drive(12'h155, 12'h0AA);
      wait_cycles(5);
      rst = 1'b0;
      #1;
      check("midreset_xpos", {20'd0, xpos}, 32'd0);
      check("midreset_ypos", {20'd0, ypos}, 32'd0);
      check("midreset_valid", {31'd0, pos_valid}, 32'd0);
      check("midreset_glitch", {24'd0, glitch_cnt}, 32'd0);
      wait_cycles(2);
      rst = 1'b1;
      expect_commit(12'h155, 12'h0AA);
      wait_cycles(12);
      check("post_reset_glitch", {24'd0, glitch_cnt}, 32'd0);

      check("scoreboard_drained", sb_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
